// File: rtl/wishbone_pwm_timer.sv
// PWM generator driven by a Wishbone-held configuration word.
// Shadowed duty/period/prescaler are applied only at period wrap, so writes never cause runt pulses.
module wishbone_pwm_timer (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] cfg_i,
  output logic        pwm_o,
  output logic        period_tick_o,
  output logic        running_o,
  output logic [11:0] cnt_o
);

  logic        run;
  logic        s_inv;
  logic [5:0]  s_presc;
  logic [11:0] s_duty;
  logic [11:0] s_per;
  logic [5:0]  pc;
  logic [11:0] cnt;

  logic tick;
  logic wrap;
  logic raw;

  assign tick = (pc == s_presc);
  assign wrap = tick && (cnt == s_per);
  assign raw  = (cnt < s_duty);

  assign running_o = run;
  assign cnt_o     = cnt;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      run           <= 1'b0;
      s_inv         <= 1'b0;
      s_presc       <= '0;
      s_duty        <= '0;
      s_per         <= '0;
      pc            <= '0;
      cnt           <= '0;
      pwm_o         <= 1'b0;
      period_tick_o <= 1'b0;
    end else begin
      // EN is never shadowed: clearing it stops the timer on the very next edge.
      run <= cfg_i[31];

      if (!run || wrap) begin
        s_inv   <= cfg_i[30];
        s_presc <= cfg_i[29:24];
        s_duty  <= cfg_i[23:12];
        s_per   <= cfg_i[11:0];
      end

      if (!run) begin
        pc            <= '0;
        cnt           <= '0;
        period_tick_o <= 1'b0;
        pwm_o         <= cfg_i[30];
      end else if (!cfg_i[31]) begin
        // Disable edge: counters clear now, output still reflects the last count.
        pc            <= '0;
        cnt           <= '0;
        period_tick_o <= 1'b0;
        pwm_o         <= raw ^ s_inv;
      end else begin
        pc <= tick ? '0 : pc + 6'd1;
        if (tick) begin
          cnt <= (cnt == s_per) ? '0 : cnt + 12'd1;
        end
        period_tick_o <= wrap;
        pwm_o         <= raw ^ s_inv;
      end
    end
  end

endmodule

// File: doc/wishbone_pwm_timer.md
# wishbone_pwm_timer

- Consumes the 32-bit configuration word held by the Wishbone register stage (its register output feeds `cfg_i` directly) and generates one PWM waveform plus a period-boundary pulse.
- Sits between the memory-mapped register and a user I/O pad.
- Configuration is shadowed and applied only at period boundaries, so firmware writes never produce runt pulses.

## Interface
Parameters:
- None. The field layout of `cfg_i` is fixed as described under Operation.

Ports:
- `wb_clk_i`  in  1  system clock. All state is updated on its rising edge.
- `wb_rst_i`  in  1  reset. Asynchronous and active-high; clears all state immediately.
- `cfg_i`  in  32  configuration word. Quasi-static; sampled every cycle.
- `pwm_o`  out  1  PWM output. Registered.
- `period_tick_o`  out  1  one-cycle pulse marking each period wrap. Registered.
- `running_o`  out  1  high while the timer is enabled.
- `cnt_o`  out  12  current period counter value, for observability.

## Operation
`cfg_i` fields:
- `[31]` EN: enable.
- `[30]` INV: output polarity.
- `[29:24]` PRESC: prescaler; a tick occurs every PRESC+1 clocks.
- `[23:12]` DUTY.
- `[11:0]` PER: the counter runs 0..PER, giving a period of PER+1 ticks.

State:
- `run` register: `run <= cfg_i[31]` every cycle.
- Shadow registers `s_inv`, `s_presc`, `s_duty`, `s_per`.
- 6-bit prescaler counter `pc`.
- 12-bit period counter `cnt`.

Shadow load rules:
- While `run`=0, the shadows load from `cfg_i` every cycle.
- While `run`=1, the shadows load only on a wrap cycle, i.e. when the tick is active and `cnt`==`s_per`.
- Exception: EN going 0 is never shadowed. When `cfg_i[31]`=0 is sampled, `run` clears on that edge.

Idle (`run`=0):
- `pc`=0, `cnt`=0, `period_tick_o`=0.
- `pwm_o` <= `cfg_i[30]`, the inactive level tracks INV.

Running (`run`=1):
- Tick = (`pc`==`s_presc`).
- Prescaler: `pc` <= tick ? 0 : `pc`+1.
- Counter on tick: `cnt` <= (`cnt`==`s_per`) ? 0 : `cnt`+1.
- `period_tick_o` <= tick && (`cnt`==`s_per`).

PWM arithmetic:
- raw = (`cnt` < `s_duty`), a 12-bit unsigned compare.
- `pwm_o` <= raw ^ `s_inv`.
- DUTY=0 gives a constant inactive level.
- DUTY>PER gives a constant active level (100 %).

Other outputs and edge cases:
- `running_o` = `run`.
- `cnt_o` = `cnt`.
- PER=0 gives a period of 1 tick, with `period_tick_o` high on every tick.
- PRESC=0 gives one tick per clock.
- A config change mid-period, other than EN, is invisible until the next wrap. The first tick after the wrap uses the new values.

## Timing
Reset values:
- `pwm_o`=0, `period_tick_o`=0, `running_o`=0, `cnt_o`=0.
- All shadows and counters = 0.

Reset behaviour:
- Reset asserted mid-operation forces these values asynchronously, without waiting for a clock edge.
- After release, the block restarts from idle.

Start-up:
- `cfg_i[31]` is sampled 1 at edge E0, so `run`=1 after E0, with the shadows loaded at E0 and `cnt`=0.
- The first tick is at edge E0+PRESC+1.

Latencies:
- `pwm_o` lags `cnt` by one clock.
- `period_tick_o` is asserted for the clock following the wrap edge.

Disable:
- Takes effect at the first edge that samples EN=0.
- `pwm_o` reaches the INV level one edge later; no completion of the current period.

## Test plan
1. Reset mid-run (PER=3, DUTY=2, running) -> assert `wb_rst_i` between edges; all outputs are 0 immediately, and `running_o` stays 0 until EN is re-sampled.
2. `cfg_i`=0x80002003 (EN, PRESC=0, DUTY=2, PER=3) -> `pwm_o` repeats 1,1,0,0 with period 4 clocks; `cnt_o` cycles 0..3; `period_tick_o` pulses once every 4 clocks.
3. `cfg_i`=0xC1001003 (EN, INV, PRESC=1, DUTY=1, PER=3) -> period 8 clocks; `pwm_o` low 2 clocks, then high 6 clocks; `period_tick_o` pulse width is 1 clock.
4. Mid-period write of DUTY=3 while running config 2 -> the current period keeps the 2/4 pattern; from the next period, 3 of 4 ticks are high.
5. Boundaries:
   - DUTY=0 with PER=5 -> `pwm_o` is constantly 0.
   - DUTY=0x00A with PER=5 -> `pwm_o` is constantly 1.
   - PER=0, PRESC=0 -> `period_tick_o` is high every clock after start.
6. Clear EN mid-period (`cnt_o`=2, PER=7) -> `running_o` goes 0 at the next edge, `cnt_o` goes 0, and `pwm_o` goes to the INV level one edge later; no further `period_tick_o`.
